// File: rtl/rx_deserializer.sv
// Serial frame receiver: FAS hunt, LSB-first byte capture, BIP-8 frame check and 3-cycle ACK return.
// Optional BIP-8 comparison is enabled by defining RX_BIP8_CHECK_EN; otherwise every complete frame checks good.
module rx_deserializer (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_otn_rx_data,
  input  logic       i_arq_en,
  output logic [7:0] o_frame_data,
  output logic       o_frame_data_valid,
  output logic       o_frame_data_fas,
  output logic       o_frame_good,
  output logic       o_frame_bad,
  output logic       o_otn_tx_ack
);

  // F6,F6,F6,28,28,28 sent LSB-first; the first bit sent ends up in bit 0.
  localparam logic [47:0] FAS          = 48'h282828_F6F6F6;
  localparam logic [12:0] FAS_BYTES    = 13'd6;
  localparam logic [12:0] LAST_PAYLOAD = 13'd4163;
  localparam logic [12:0] FRAME_BYTES  = 13'd4164;

  typedef enum logic [2:0] {
    S_HUNT,
    S_CAPTURE,
    S_CHECK,
    S_ACK_START,
    S_ACK_BIT,
    S_ACK_STOP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sync1;
  logic        r_rx_s;
  logic [47:0] r_hist;
  logic [2:0]  r_bit_cnt;
  logic [12:0] r_byte_cnt;
  logic [6:0]  r_shift;
  logic        r_result;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_fas;
  logic        r_good;
  logic        r_bad;
  logic        r_ack;

  logic        w_bit;
  logic [7:0]  w_byte;
  logic [12:0] w_byte_num;
  logic        w_fas_hit;
  logic        w_byte_done;
  logic        w_frame_end;
  logic        w_check_ok;
  logic        w_ack_nxt;

  // The lock decision is made on the registered history, so capture reads the
  // newest history bit to stay aligned with the first payload bit.
  assign w_bit       = r_hist[47];
  assign w_byte      = {w_bit, r_shift};
  assign w_byte_num  = r_byte_cnt + 13'd1;
  assign w_fas_hit   = (r_state == S_HUNT) && (r_hist == FAS);
  assign w_byte_done = (r_state == S_CAPTURE) && (r_bit_cnt == 3'd7);
  assign w_frame_end = w_byte_done && (w_byte_num == FRAME_BYTES);

`ifdef RX_BIP8_CHECK_EN
  logic [7:0] r_bip;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bip <= 8'h00;
    end else if (w_fas_hit) begin
      r_bip <= 8'h00;
    end else if (w_byte_done && (w_byte_num <= LAST_PAYLOAD)) begin
      r_bip <= r_bip ^ w_byte;
    end
  end

  assign w_check_ok = (w_byte == r_bip);
`else
  assign w_check_ok = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = 1'b1;
    case (r_state)
      S_HUNT:      if (w_fas_hit) w_state_nxt = S_CAPTURE;
      S_CAPTURE:   if (w_frame_end) w_state_nxt = S_CHECK;
      S_CHECK:     w_state_nxt = i_arq_en ? S_ACK_START : S_HUNT;
      S_ACK_START: w_state_nxt = S_ACK_BIT;
      S_ACK_BIT:   w_state_nxt = S_ACK_STOP;
      S_ACK_STOP:  w_state_nxt = S_HUNT;
      default:     w_state_nxt = S_HUNT;
    endcase
    // ACK line is registered so its value tracks the state being entered.
    case (w_state_nxt)
      S_ACK_START: w_ack_nxt = 1'b0;
      S_ACK_BIT:   w_ack_nxt = r_result;
      S_ACK_STOP:  w_ack_nxt = 1'b0;
      default:     w_ack_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1    <= 1'b1;
      r_rx_s     <= 1'b1;
      r_hist     <= '1;
      r_bit_cnt  <= 3'd0;
      r_byte_cnt <= 13'd0;
      r_shift    <= 7'd0;
      r_result   <= 1'b0;
      r_data     <= 8'h00;
      r_valid    <= 1'b0;
      r_fas      <= 1'b0;
      r_good     <= 1'b0;
      r_bad      <= 1'b0;
      r_ack      <= 1'b1;
    end else begin
      r_sync1 <= i_otn_rx_data;
      r_rx_s  <= r_sync1;
      r_hist  <= {r_rx_s, r_hist[47:1]};
      r_valid <= 1'b0;
      r_fas   <= 1'b0;
      r_good  <= 1'b0;
      r_bad   <= 1'b0;
      r_ack   <= w_ack_nxt;
      if (w_fas_hit) begin
        r_bit_cnt  <= 3'd0;
        r_byte_cnt <= FAS_BYTES;
        r_fas      <= 1'b1;
      end
      if (r_state == S_CAPTURE) begin
        r_shift   <= w_byte[7:1];
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (w_byte_done) begin
          r_byte_cnt <= w_byte_num;
          if (w_byte_num <= LAST_PAYLOAD) begin
            r_data  <= w_byte;
            r_valid <= 1'b1;
          end
        end
        if (w_frame_end) begin
          r_result <= w_check_ok;
          r_good   <= w_check_ok;
          r_bad    <= !w_check_ok;
        end
      end
    end
  end

  assign o_frame_data       = r_data;
  assign o_frame_data_valid = r_valid;
  assign o_frame_data_fas   = r_fas;
  assign o_frame_good       = r_good;
  assign o_frame_bad        = r_bad;
  assign o_otn_tx_ack       = r_ack;

endmodule

// File: tb/tb_rx_deserializer.sv
// Directed bench for rx_deserializer: reset, idle line, aborted frame, good frame with embedded FAS,
// and a frame with a zero BIP byte whose outcome depends on RX_BIP8_CHECK_EN.
module tb_rx_deserializer;

`ifdef RX_BIP8_CHECK_EN
  localparam bit BIP_EN = 1'b1;
`else
  localparam bit BIP_EN = 1'b0;
`endif
  localparam int NPAY = 4157;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       arq;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_fas;
  logic       o_good;
  logic       o_bad;
  logic       o_ack;

  rx_deserializer dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_otn_rx_data      (rx),
    .i_arq_en           (arq),
    .o_frame_data       (o_data),
    .o_frame_data_valid (o_valid),
    .o_frame_data_fas   (o_fas),
    .o_frame_good       (o_good),
    .o_frame_bad        (o_bad),
    .o_otn_tx_ack       (o_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] payload [NPAY];
  int v_cnt = 0, v_base = 0, data_err = 0;
  int fas_cnt = 0, good_cnt = 0, bad_cnt = 0, both_cnt = 0, ack_low = 0;

  always @(negedge clk) begin
    if (o_valid) begin
      if ((v_cnt - v_base) < NPAY && o_data !== payload[v_cnt - v_base]) data_err++;
      v_cnt++;
    end
    if (o_fas) fas_cnt++;
    if (o_good) good_cnt++;
    if (o_bad) bad_cnt++;
    if (o_good && o_bad) both_cnt++;
    if (!o_ack) ack_low++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx = b[i];
    end
  endtask

  task automatic send_fas();
    send_byte(8'hF6); send_byte(8'hF6); send_byte(8'hF6);
    send_byte(8'h28); send_byte(8'h28); send_byte(8'h28);
  endtask

  task automatic send_payload(input int n);
    for (int k = 0; k < n; k++) send_byte(payload[k]);
  endtask

  function automatic logic [7:0] calc_bip();
    logic [7:0] x = 8'h00;
    for (int k = 0; k < NPAY; k++) x ^= payload[k];
    return x;
  endfunction

  // Wait for the check pulse, then verify the ACK line over the following cycles.
  task automatic finish_frame(input string tag, input logic arq_chk, input logic exp_good);
    logic found = 1'b0;
    logic [2:0] exp_ack;
    arq = arq_chk;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      rx = 1'b1;
      if (o_good || o_bad) found = 1'b1;
    end
    chk({tag, "_check_seen"}, 32'(found), 32'd1);
    chk({tag, "_good"}, 32'(o_good), 32'(exp_good));
    chk({tag, "_bad"}, 32'(o_bad), 32'(!exp_good));
    chk({tag, "_ack_check"}, 32'(o_ack), 32'd1);
    exp_ack = arq_chk ? {1'b0, exp_good, 1'b0} : 3'b111;
    for (int p = 2; p >= 0; p--) begin
      @(negedge clk);
      chk({tag, "_ack_phase"}, 32'(o_ack), 32'(exp_ack[p]));
    end
    @(negedge clk);
    chk({tag, "_ack_idle"}, 32'(o_ack), 32'd1);
    chk({tag, "_no_pulse"}, 32'(o_good | o_bad), 32'd0);
  endtask

  initial begin
    int fas0, good0, bad0;
    logic [7:0] bip;
    rx  = 1'b1;
    arq = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < NPAY; k++) payload[k] = 8'hA5;
    repeat (4) @(negedge clk);
    chk("rst_data", 32'(o_data), 32'h00);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_fas", 32'(o_fas), 32'd0);
    chk("rst_good", 32'(o_good), 32'd0);
    chk("rst_bad", 32'(o_bad), 32'd0);
    chk("rst_ack", 32'(o_ack), 32'd1);
    rst = 1'b0;
    ack_low = 0;

    repeat (100) @(negedge clk);
    #1;
    chk("idle_fas", 32'(fas_cnt), 32'd0);
    chk("idle_valid", 32'(v_cnt), 32'd0);
    chk("idle_ack_low", 32'(ack_low), 32'd0);

    // Frame aborted by reset after 2000 payload bytes.
    v_base = v_cnt;
    send_fas();
    send_payload(2000);
    @(negedge clk);
    rst = 1'b1;
    arq = 1'b1;
    @(negedge clk);
    chk("abort_ack", 32'(o_ack), 32'd1);
    chk("abort_valid", 32'(o_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("abort_fas", 32'(fas_cnt), 32'd1);
    chk("abort_good", 32'(good_cnt), 32'd0);
    chk("abort_bad", 32'(bad_cnt), 32'd0);
    chk("abort_data_err", 32'(data_err), 32'd0);

    // Good frame with FAS embedded at frame bytes 100..105; ARQ off during capture.
    payload[93] = 8'hF6; payload[94] = 8'hF6; payload[95] = 8'hF6;
    payload[96] = 8'h28; payload[97] = 8'h28; payload[98] = 8'h28;
    bip = calc_bip();
    chk("model_bip", 32'(bip), 32'h7B);
    arq = 1'b0;
    #1;
    v_base = v_cnt;
    fas0 = fas_cnt;
    send_fas();
    send_payload(NPAY);
    send_byte(bip);
    finish_frame("frameA", 1'b1, 1'b1);
    #1;
    chk("frameA_fas", 32'(fas_cnt - fas0), 32'd1);
    chk("frameA_valid", 32'(v_cnt - v_base), 32'(NPAY));
    chk("frameA_data_err", 32'(data_err), 32'd0);
    chk("frameA_good_cnt", 32'(good_cnt), 32'd1);

    // All-A5 frame with BIP byte 00; ARQ on during capture.
    for (int k = 0; k < NPAY; k++) payload[k] = 8'hA5;
    repeat (5) @(negedge clk);
    arq = 1'b1;
    #1;
    v_base = v_cnt;
    fas0 = fas_cnt;
    good0 = good_cnt;
    bad0 = bad_cnt;
    send_fas();
    send_payload(NPAY);
    send_byte(8'h00);
    finish_frame("frameB", BIP_EN, !BIP_EN);
    #1;
    chk("frameB_fas", 32'(fas_cnt - fas0), 32'd1);
    chk("frameB_valid", 32'(v_cnt - v_base), 32'(NPAY));
    chk("frameB_data_err", 32'(data_err), 32'd0);
    chk("frameB_good_cnt", 32'(good_cnt - good0), 32'(!BIP_EN));
    chk("frameB_bad_cnt", 32'(bad_cnt - bad0), 32'(BIP_EN));
    chk("both_pulses", 32'(both_cnt), 32'd0);
    chk("ack_low_total", 32'(ack_low), BIP_EN ? 32'd5 : 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
